// File: rtl/tlul_pkg.sv
// TL-UL bus payload types shared by hosts, devices and adapters.
package tlul_pkg;

    localparam int unsigned TL_AW = 32;
    localparam int unsigned TL_DW = 32;
    localparam int unsigned TL_AIW = 8;
    localparam int unsigned TL_DIW = 1;
    localparam int unsigned TL_DBW = TL_DW / 8;
    localparam int unsigned TL_SZW = 2;
    localparam int unsigned RsvdWidth = 5;
    localparam int unsigned H2DCmdIntgWidth = 7;
    localparam int unsigned D2HRspIntgWidth = 7;
    localparam int unsigned DataIntgWidth = 7;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [RsvdWidth-1:0]       rsvd;
        logic [3:0]                 instr_type;
        logic [H2DCmdIntgWidth-1:0] cmd_intg;
        logic [DataIntgWidth-1:0]   data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [D2HRspIntgWidth-1:0] rsp_intg;
        logic [DataIntgWidth-1:0]   data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        tl_a_op_e          a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        tl_d_op_e          d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/top_racl_pkg.sv
// RACL role/UID types, error log payload and the rsvd-field stamping/extraction helpers.
package top_racl_pkg;

    localparam int unsigned RACL_ROLE_W = 4;
    localparam int unsigned CTN_UID_W = 8;
    localparam int unsigned RACL_ROLE_LSB = 0;
    localparam int unsigned CTN_UID_LSB = 4;

    typedef logic [RACL_ROLE_W-1:0] racl_role_t;
    typedef logic [CTN_UID_W-1:0]   ctn_uid_t;

    typedef struct packed {
        logic                         valid;
        logic                         overflow;
        racl_role_t                   racl_role;
        ctn_uid_t                     ctn_uid;
        logic                         read_access;
        logic [tlul_pkg::TL_AW-1:0]   request_address;
    } racl_error_log_t;

    // Wide enough that role/UID fields never fall off the top before truncation to rsvd.
    localparam int unsigned RsvdPadW = tlul_pkg::RsvdWidth + RACL_ROLE_LSB + RACL_ROLE_W
                                     + CTN_UID_LSB + CTN_UID_W;

    function automatic racl_role_t tlul_extract_racl_role_bits(
        input logic [tlul_pkg::RsvdWidth-1:0] rsvd
    );
        return RACL_ROLE_W'(RsvdPadW'(rsvd) >> RACL_ROLE_LSB);
    endfunction

    function automatic ctn_uid_t tlul_extract_ctn_uid_bits(
        input logic [tlul_pkg::RsvdWidth-1:0] rsvd
    );
        return CTN_UID_W'(RsvdPadW'(rsvd) >> CTN_UID_LSB);
    endfunction

    // Overlay role and UID onto rsvd; any field bits at or above RsvdWidth are dropped.
    function automatic logic [tlul_pkg::RsvdWidth-1:0] tlul_insert_racl_bits(
        input logic [tlul_pkg::RsvdWidth-1:0] rsvd,
        input racl_role_t                     role,
        input ctn_uid_t                       ctn_uid
    );
        return tlul_pkg::RsvdWidth'(
              (RsvdPadW'(rsvd)
                 & ~(RsvdPadW'(racl_role_t'('1)) << RACL_ROLE_LSB)
                 & ~(RsvdPadW'(ctn_uid_t'('1)) << CTN_UID_LSB))
            | (RsvdPadW'(role) << RACL_ROLE_LSB)
            | (RsvdPadW'(ctn_uid) << CTN_UID_LSB));
    endfunction

endpackage

// File: rtl/prim_fifo_sync.sv
// Minimal synchronous FIFO; occupancy is owned by the caller, pointers wrap naturally.
module prim_fifo_sync #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wvalid_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             rready_i,
    output logic [Width-1:0] rdata_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wptr_q;
    logic [PtrW-1:0]  rptr_q;
    logic [Width-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wvalid_i) begin
                wptr_q <= wptr_q + PtrW'(1);
            end
            if (rready_i) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wvalid_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q];

endmodule

// File: rtl/tlul_racl_role_stamper.sv
// Stamps a stable RACL role/CTN UID into TL-UL A-channel rsvd bits, bounds outstanding
// requests and logs the first erroring response against its originating request.
module tlul_racl_role_stamper
    import tlul_pkg::*;
    import top_racl_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  tlul_pkg::tl_h2d_t                 tl_h_i,
    output tlul_pkg::tl_d2h_t                 tl_h_o,
    output tlul_pkg::tl_h2d_t                 tl_d_o,
    input  tlul_pkg::tl_d2h_t                 tl_d_i,
    input  top_racl_pkg::racl_role_t          role_i,
    input  logic [top_racl_pkg::CTN_UID_W-1:0] ctn_uid_i,
    input  logic                              err_clr_i,
    output top_racl_pkg::racl_error_log_t     err_log_o,
    output logic                              busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic [TL_AW-1:0] addr;
        logic             read;
    } trk_t;

    localparam int unsigned TrkW = $bits(trk_t);

    logic [CntW-1:0] cnt_q, cnt_d;
    racl_role_t      role_q;
    ctn_uid_t        uid_q;
    racl_error_log_t log_q, log_d;
    logic            busy_q;
    logic            full;
    logic            a_hs;
    logic            d_hs;
    trk_t            trk_wdata;
    trk_t            trk_rdata;

    assign full = (cnt_q == CntW'(MaxOutstanding));

    // Request path: pass-through with stamped rsvd and a stall once the window is full.
    always_comb begin
        tl_d_o                = tl_h_i;
        tl_d_o.a_valid        = tl_h_i.a_valid & ~full;
        tl_d_o.a_user.rsvd    = tlul_insert_racl_bits(tl_h_i.a_user.rsvd, role_q, uid_q);
    end

    always_comb begin
        tl_h_o         = tl_d_i;
        tl_h_o.a_ready = tl_d_i.a_ready & ~full;
    end

    assign a_hs = tl_d_o.a_valid & tl_d_i.a_ready;
    // Responses with nothing outstanding are a protocol violation and do not touch tracking.
    assign d_hs = tl_d_i.d_valid & tl_h_i.d_ready & (cnt_q != '0);

    assign trk_wdata.addr = tl_h_i.a_address;
    assign trk_wdata.read = (tl_h_i.a_opcode == Get);

    prim_fifo_sync #(
        .Width (TrkW),
        .Depth (MaxOutstanding)
    ) u_trk_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wvalid_i (a_hs),
        .wdata_i  (trk_wdata),
        .rready_i (d_hs),
        .rdata_o  (trk_rdata)
    );

    always_comb begin
        cnt_d = cnt_q;
        log_d = log_q;

        case ({a_hs, d_hs})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase

        // A clear coinciding with a new error yields a fresh capture rather than an overflow.
        if (d_hs && tl_d_i.d_error) begin
            if (!log_q.valid || err_clr_i) begin
                log_d.valid           = 1'b1;
                log_d.overflow        = 1'b0;
                log_d.racl_role       = role_q;
                log_d.ctn_uid         = uid_q;
                log_d.read_access     = trk_rdata.read;
                log_d.request_address = trk_rdata.addr;
            end else begin
                log_d.overflow = 1'b1;
            end
        end else if (err_clr_i) begin
            log_d.valid    = 1'b0;
            log_d.overflow = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            role_q <= '0;
            uid_q  <= '0;
            log_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            log_q  <= log_d;
            busy_q <= (cnt_d != '0);
            // Role/UID only change while idle so every in-flight request shares one identity.
            if ((cnt_q == '0) && !a_hs) begin
                role_q <= role_i;
                uid_q  <= ctn_uid_i;
            end
        end
    end

    assign err_log_o = log_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_tlul_racl_role_stamper.sv
// Bench for tlul_racl_role_stamper: stamping vectors, directed corner sequences and random traffic.
`timescale 1ns/1ps
module tb_tlul_racl_role_stamper;
    import tlul_pkg::*;
    import top_racl_pkg::*;

    localparam int unsigned MaxOut = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    tl_h2d_t         h_in;
    tl_d2h_t         h_out;
    tl_h2d_t         d_out;
    tl_d2h_t         d_in;
    racl_role_t      role;
    logic [7:0]      uid;
    logic            err_clr;
    racl_error_log_t err_log;
    logic            busy;

    tlul_racl_role_stamper #(.MaxOutstanding(MaxOut)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .tl_h_i    (h_in),
        .tl_h_o    (h_out),
        .tl_d_o    (d_out),
        .tl_d_i    (d_in),
        .role_i    (role),
        .ctn_uid_i (uid),
        .err_clr_i (err_clr),
        .err_log_o (err_log),
        .busy_o    (busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: queue of outstanding requests in issue order.
    typedef struct {
        logic [31:0] addr;
        bit          read;
    } req_t;
    req_t            m_q[$];
    racl_role_t      m_role;
    logic [7:0]      m_uid;
    racl_error_log_t m_log;

    typedef struct {
        racl_role_t  role;
        logic [7:0]  uid;
        logic [4:0]  rsvd_in;
        logic [31:0] addr;
        logic [4:0]  exp_rsvd;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: compare combinational paths mid-cycle, advance model at the edge, compare state.
    task automatic cycle();
        bit stall;
        bit acc;
        bit dhs;
        @(negedge clk);
        stall = (m_q.size() == MaxOut);
        chk("a_valid_dev", 64'(d_out.a_valid), 64'(h_in.a_valid && !stall));
        chk("a_ready_host", 64'(h_out.a_ready), 64'(d_in.a_ready && !stall));
        chk("rsvd_stamp", 64'(d_out.a_user.rsvd), 64'({m_uid[0], m_role}));
        chk("a_addr_pass", 64'(d_out.a_address), 64'(h_in.a_address));
        chk("a_intg_pass", 64'({d_out.a_user.cmd_intg, d_out.a_user.data_intg, d_out.a_data}),
            64'({h_in.a_user.cmd_intg, h_in.a_user.data_intg, h_in.a_data}));
        chk("d_pass", 64'({h_out.d_valid, h_out.d_error, h_out.d_data, d_out.d_ready}),
            64'({d_in.d_valid, d_in.d_error, d_in.d_data, h_in.d_ready}));
        acc = h_in.a_valid && d_in.a_ready && !stall;
        dhs = d_in.d_valid && h_in.d_ready && (m_q.size() != 0);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_role = '0;
            m_uid  = '0;
            m_log  = '0;
        end else begin
            if (dhs && d_in.d_error) begin
                if (!m_log.valid || err_clr) begin
                    m_log.valid           = 1'b1;
                    m_log.overflow        = 1'b0;
                    m_log.racl_role       = m_role;
                    m_log.ctn_uid         = m_uid;
                    m_log.read_access     = m_q[0].read;
                    m_log.request_address = m_q[0].addr;
                end else begin
                    m_log.overflow = 1'b1;
                end
            end else if (err_clr) begin
                m_log.valid    = 1'b0;
                m_log.overflow = 1'b0;
            end
            if (m_q.size() == 0 && !acc) begin
                m_role = role;
                m_uid  = uid;
            end
            if (dhs) void'(m_q.pop_front());
            if (acc) m_q.push_back('{h_in.a_address, h_in.a_opcode == Get});
        end
        #1;
        chk("busy", 64'(busy), 64'(m_q.size() != 0));
        chk("err_log", 64'(err_log), 64'(m_log));
    endtask

    task automatic issue(input tl_a_op_e op, input logic [31:0] addr);
        h_in.a_valid   = 1'b1;
        h_in.a_opcode  = op;
        h_in.a_address = addr;
        d_in.a_ready   = 1'b1;
        d_in.d_valid   = 1'b0;
        cycle();
        h_in.a_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        h_in.a_valid = 1'b0;
        h_in.d_ready = 1'b1;
        d_in.d_valid = 1'b1;
        d_in.d_error = 1'b0;
        while (m_q.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        d_in.d_valid = 1'b0;
        chk("drain_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        vecs[0] = '{4'h5, 8'h01, 5'h00, 32'h100, 5'h15};
        vecs[1] = '{4'h9, 8'h00, 5'h1F, 32'h104, 5'h09};
        vecs[2] = '{4'h0, 8'hFE, 5'h1F, 32'h200, 5'h00};
        vecs[3] = '{4'hF, 8'h03, 5'h00, 32'h3FC, 5'h1F};

        rst_n = 1'b0;
        h_in = '0;
        d_in = '0;
        h_in.d_ready = 1'b1;
        role = '0;
        uid = '0;
        err_clr = 1'b0;
        m_role = '0;
        m_uid = '0;
        m_log = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_log", 64'(err_log), 64'(0));
        rst_n = 1'b1;

        // Stamping vectors: load identity while idle, then present an unaccepted Put.
        for (int i = 0; i < 4; i++) begin
            role = vecs[i].role;
            uid = vecs[i].uid;
            h_in.a_valid = 1'b0;
            d_in.a_ready = 1'b0;
            cycle();
            h_in.a_valid = 1'b1;
            h_in.a_opcode = PutFullData;
            h_in.a_address = vecs[i].addr;
            h_in.a_user.rsvd = vecs[i].rsvd_in;
            h_in.a_user.cmd_intg = 7'(i * 13 + 5);
            cycle();
            chk("vec_rsvd", 64'(d_out.a_user.rsvd), 64'(vecs[i].exp_rsvd));
            chk("vec_addr", 64'(d_out.a_address), 64'(vecs[i].addr));
        end
        h_in.a_valid = 1'b0;
        h_in.a_user.rsvd = '0;

        // Window limit: fifth Get stalls until one response retires.
        role = 4'h5;
        uid = 8'h01;
        cycle();
        h_in.a_valid = 1'b1;
        h_in.a_opcode = Get;
        h_in.a_address = 32'h200;
        d_in.a_ready = 1'b1;
        repeat (4) cycle();
        chk("stall_a_ready", 64'(h_out.a_ready), 64'(0));
        chk("stall_a_valid", 64'(d_out.a_valid), 64'(0));
        chk("stall_busy", 64'(busy), 64'(1));
        cycle();
        d_in.d_valid = 1'b1;
        cycle();
        d_in.d_valid = 1'b0;
        chk("resume_a_ready", 64'(h_out.a_ready), 64'(1));
        cycle();
        drain();

        // First-error capture, overflow, clear.
        issue(Get, 32'h40);
        issue(PutFullData, 32'h80);
        d_in.d_valid = 1'b1;
        d_in.d_error = 1'b1;
        cycle();
        chk("err1_valid", 64'(err_log.valid), 64'(1));
        chk("err1_addr", 64'(err_log.request_address), 64'h40);
        chk("err1_read", 64'(err_log.read_access), 64'(1));
        chk("err1_ovf", 64'(err_log.overflow), 64'(0));
        chk("err1_role", 64'(err_log.racl_role), 64'h5);
        cycle();
        chk("err2_addr", 64'(err_log.request_address), 64'h40);
        chk("err2_ovf", 64'(err_log.overflow), 64'(1));
        d_in.d_valid = 1'b0;
        d_in.d_error = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clr_valid", 64'(err_log.valid), 64'(0));
        chk("clr_ovf", 64'(err_log.overflow), 64'(0));

        // Clear in the same cycle as a new error: new capture wins.
        issue(Get, 32'h40);
        issue(PutFullData, 32'hC0);
        d_in.d_valid = 1'b1;
        d_in.d_error = 1'b1;
        cycle();
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("clrnew_addr", 64'(err_log.request_address), 64'hC0);
        chk("clrnew_read", 64'(err_log.read_access), 64'(0));
        chk("clrnew_ovf", 64'(err_log.overflow), 64'(0));
        d_in.d_valid = 1'b0;
        d_in.d_error = 1'b0;
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;

        // Role change while requests are in flight is deferred until idle.
        issue(Get, 32'h10);
        issue(Get, 32'h14);
        role = 4'h9;
        h_in.a_valid = 1'b1;
        d_in.a_ready = 1'b0;
        cycle();
        chk("role_hold", 64'(d_out.a_user.rsvd[3:0]), 64'h5);
        d_in.d_valid = 1'b1;
        cycle();
        cycle();
        chk("role_hold_last", 64'(d_out.a_user.rsvd[3:0]), 64'h5);
        d_in.d_valid = 1'b0;
        cycle();
        chk("role_new", 64'(d_out.a_user.rsvd[3:0]), 64'h9);
        h_in.a_valid = 1'b0;

        // Reset with three outstanding and a logged error; late responses are ignored.
        repeat (4) issue(Get, 32'h300);
        d_in.d_valid = 1'b1;
        d_in.d_error = 1'b1;
        cycle();
        d_in.d_valid = 1'b0;
        chk("pre_rst_log", 64'(err_log.valid), 64'(1));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_log", 64'(err_log), 64'(0));
        d_in.d_valid = 1'b1;
        cycle();
        chk("late_busy", 64'(busy), 64'(0));
        chk("late_log", 64'(err_log), 64'(0));
        d_in.d_valid = 1'b0;
        d_in.d_error = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            h_in.a_valid = ($urandom_range(0, 2) != 0);
            h_in.a_opcode = ($urandom_range(0, 1) != 0) ? Get : PutFullData;
            h_in.a_address = $urandom;
            h_in.a_data = $urandom;
            h_in.a_user.rsvd = 5'($urandom);
            h_in.a_user.cmd_intg = 7'($urandom);
            h_in.a_user.data_intg = 7'($urandom);
            h_in.d_ready = ($urandom_range(0, 3) != 0);
            d_in.a_ready = ($urandom_range(0, 3) != 0);
            d_in.d_valid = ($urandom_range(0, 2) == 0);
            d_in.d_error = ($urandom_range(0, 3) == 0);
            d_in.d_data = $urandom;
            role = 4'($urandom);
            uid = 8'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1'b1;
        err_clr = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
